mem_write_tracer: RTL and testbench

Synthesizable capture block for the CPU data-memory write bus. It classifies every write into one of NUM_REGIONS address windows, for example the image-out and data regions. Matched writes are time-stamped and buffered in a FIFO, and a valid/ready readout port drains them. A programmable stop-PC freezes capture, and per-region, unmatched and dropped-write counters are kept. It sits beside the CPU/DataMemoryManager on the data bus, with an inst-address tap, and replaces file-based write logging on hardware.

---
 rtl/mem_write_tracer.sv | 187 ++++++++++++++++++
 tb/tb_mem_write_tracer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_write_tracer.sv
// Data-bus write tracer: classifies CPU data-memory writes into address windows,
// time-stamps matched writes into a FIFO drained over a valid/ready port, and keeps statistics.
module mem_write_tracer #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_REGIONS = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int STAMP_W     = 16,
    parameter int CNT_W       = 16,
    localparam int REG_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base_i,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_limit_i,
    input  logic                          stop_en_i,
    input  logic [ADDR_W-1:0]             stop_addr_i,
    input  logic [ADDR_W-1:0]             inst_addr_i,
    input  logic [ADDR_W-1:0]             wr_addr_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    input  logic                          wr_en_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [REG_W-1:0]              out_region_o,
    output logic [ADDR_W-1:0]             out_offset_o,
    output logic [DATA_W-1:0]             out_data_o,
    output logic [STAMP_W-1:0]            out_stamp_o,
    output logic [NUM_REGIONS*CNT_W-1:0]  region_cnt_o,
    output logic [CNT_W-1:0]              unmatched_cnt_o,
    output logic [CNT_W-1:0]              drop_cnt_o,
    output logic                          overflow_o,
    output logic [1:0]                    state_o,
    output logic                          done_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = REG_W + ADDR_W + DATA_W + STAMP_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_STOPPED = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [STAMP_W-1:0]   stamp_q, stamp_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic [CNT_W-1:0]     region_cnt_q [NUM_REGIONS];
    logic [CNT_W-1:0]     region_cnt_d [NUM_REGIONS];
    logic [CNT_W-1:0]     unmatched_q, unmatched_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
    logic                 overflow_q, overflow_d;
    logic [ENT_W-1:0]     fifo_mem_q [FIFO_DEPTH];

    logic                 hit;
    logic [REG_W-1:0]     hit_idx;
    logic [ADDR_W-1:0]    hit_base;
    logic                 wr_valid, full, pop, push, drop;
    logic [ENT_W-1:0]     head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Walk windows from highest to lowest so the lowest matching index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_base = '0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if (region_base_i[k*ADDR_W +: ADDR_W] <= wr_addr_i &&
                wr_addr_i <= region_limit_i[k*ADDR_W +: ADDR_W]) begin
                hit      = 1'b1;
                hit_idx  = REG_W'(k);
                hit_base = region_base_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign wr_valid = (state_q == S_CAPTURE) && wr_en_i;
    assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign pop      = (count_q != '0) && out_ready_i;
    assign push     = wr_valid && hit && (!full || pop);
    assign drop     = wr_valid && hit && !push;

    always_comb begin
        state_d      = state_q;
        stamp_d      = stamp_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        region_cnt_d = region_cnt_q;
        unmatched_d  = unmatched_q;
        drop_d       = drop_q;
        overflow_d   = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                stamp_d = stamp_q + 1'b1;
                if (stop_en_i && inst_addr_i == stop_addr_i) state_d = S_STOPPED;
            end
            S_STOPPED: ;
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (push && hit_idx == REG_W'(k)) region_cnt_d[k] = sat_inc(region_cnt_q[k]);
        end
        if (wr_valid && !hit) unmatched_d = sat_inc(unmatched_q);
        if (drop) begin
            drop_d     = sat_inc(drop_q);
            overflow_d = 1'b1;
        end

        // Flush overrides everything computed above.
        if (clear_i) begin
            state_d    = S_IDLE;
            stamp_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            for (int k = 0; k < NUM_REGIONS; k++) region_cnt_d[k] = '0;
            unmatched_d = '0;
            drop_d      = '0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            stamp_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int k = 0; k < NUM_REGIONS; k++) region_cnt_q[k] <= '0;
            unmatched_q <= '0;
            drop_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            stamp_q      <= stamp_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            region_cnt_q <= region_cnt_d;
            unmatched_q  <= unmatched_d;
            drop_q       <= drop_d;
            overflow_q   <= overflow_d;
        end
    end

    // Trace storage carries no reset; stale entries are masked by occupancy.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {hit_idx, wr_addr_i - hit_base, wr_data_i, stamp_q};
    end

    assign head         = fifo_mem_q[rd_ptr_q];
    assign out_valid_o  = (count_q != '0);
    assign out_stamp_o  = out_valid_o ? head[0 +: STAMP_W] : '0;
    assign out_data_o   = out_valid_o ? head[STAMP_W +: DATA_W] : '0;
    assign out_offset_o = out_valid_o ? head[STAMP_W+DATA_W +: ADDR_W] : '0;
    assign out_region_o = out_valid_o ? head[STAMP_W+DATA_W+ADDR_W +: REG_W] : '0;

    always_comb begin
        region_cnt_o = '0;
        for (int k = 0; k < NUM_REGIONS; k++) region_cnt_o[k*CNT_W +: CNT_W] = region_cnt_q[k];
    end

    assign unmatched_cnt_o = unmatched_q;
    assign drop_cnt_o      = drop_q;
    assign overflow_o      = overflow_q;
    assign state_o         = state_q;
    assign done_o          = (state_q == S_STOPPED);

endmodule

// File: tb/tb_mem_write_tracer.sv
// Directed bench for mem_write_tracer: small FIFO and narrow counters so overflow
// and saturation are reachable in a few cycles.
module tb_mem_write_tracer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int FD = 4;
    localparam int SW = 16;
    localparam int CW = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic           enable_i, clear_i;
    logic [NR*AW-1:0] region_base_i, region_limit_i;
    logic           stop_en_i;
    logic [AW-1:0]  stop_addr_i, inst_addr_i, wr_addr_i;
    logic [DW-1:0]  wr_data_i;
    logic           wr_en_i;
    logic           out_valid_o, out_ready_i;
    logic [0:0]     out_region_o;
    logic [AW-1:0]  out_offset_o;
    logic [DW-1:0]  out_data_o;
    logic [SW-1:0]  out_stamp_o;
    logic [NR*CW-1:0] region_cnt_o;
    logic [CW-1:0]  unmatched_cnt_o, drop_cnt_o;
    logic           overflow_o;
    logic [1:0]     state_o;
    logic           done_o;

    int total = 0;
    int bad   = 0;

    mem_write_tracer #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGIONS(NR),
        .FIFO_DEPTH(FD), .STAMP_W(SW), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST(RST), .enable_i(enable_i), .clear_i(clear_i),
        .region_base_i(region_base_i), .region_limit_i(region_limit_i),
        .stop_en_i(stop_en_i), .stop_addr_i(stop_addr_i), .inst_addr_i(inst_addr_i),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_en_i(wr_en_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_region_o(out_region_o), .out_offset_o(out_offset_o),
        .out_data_o(out_data_o), .out_stamp_o(out_stamp_o),
        .region_cnt_o(region_cnt_o), .unmatched_cnt_o(unmatched_cnt_o),
        .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o),
        .state_o(state_o), .done_o(done_o)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic set_regions(input logic [AW-1:0] b0, l0, b1, l1);
        region_base_i  = {b1, b0};
        region_limit_i = {l1, l0};
    endtask

    initial begin
        RST = 1'b0; enable_i = 1'b0; clear_i = 1'b0;
        stop_en_i = 1'b0; stop_addr_i = '0; inst_addr_i = '0;
        wr_addr_i = '0; wr_data_i = '0; wr_en_i = 1'b0; out_ready_i = 1'b0;
        set_regions(32'd0, 32'd4095, 32'd262144, 32'd327679);
        tick(); tick();

        check_eq("rst_state", state_o, 2'b00);
        check_eq("rst_valid", out_valid_o, 1'b0);
        check_eq("rst_cnts", {region_cnt_o, unmatched_cnt_o, drop_cnt_o}, '0);
        check_eq("rst_flags", {overflow_o, done_o}, 2'b00);
        check_eq("rst_data", out_data_o, '0);
        RST = 1'b1;

        // Enable, idle two capture cycles (stamp 0,1), write at stamp 2.
        enable_i = 1'b1; tick(); enable_i = 1'b0;
        check_eq("en_state", state_o, 2'b01);
        tick(); tick();
        wr(32'd262150, 32'hAB);
        check_eq("r1_valid", out_valid_o, 1'b1);
        check_eq("r1_region", out_region_o, 1'b1);
        check_eq("r1_offset", out_offset_o, 32'd6);
        check_eq("r1_data", out_data_o, 32'hAB);
        check_eq("r1_stamp", out_stamp_o, 16'd2);
        check_eq("r1_cnt", region_cnt_o[7:4], 4'd1);
        out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
        check_eq("r1_popped", out_valid_o, 1'b0);

        // Overlapping windows: lowest index wins. Stamp is now 4.
        set_regions(32'd0, 32'd4095, 32'd100, 32'd200);
        wr(32'd150, 32'h11);
        check_eq("ov_region", out_region_o, 1'b0);
        check_eq("ov_offset", out_offset_o, 32'd150);
        check_eq("ov_stamp", out_stamp_o, 16'd4);
        wr(32'd5000, 32'h22);
        check_eq("um_cnt", unmatched_cnt_o, 4'd1);
        check_eq("um_hold", out_offset_o, 32'd150);
        // Empty window (base > limit) never matches.
        set_regions(32'd0, 32'd4095, 32'd300000, 32'd299000);
        wr(32'd299500, 32'h33);
        check_eq("empty_um", unmatched_cnt_o, 4'd2);
        check_eq("empty_r1", region_cnt_o[7:4], 4'd1);
        out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
        check_eq("ov_popped", out_valid_o, 1'b0);

        // Fill a depth-4 FIFO with 6 writes: 2 drops.
        for (int i = 0; i < 6; i++) wr(32'(10 + i), 32'(i));
        check_eq("ful_drop", drop_cnt_o, 4'd2);
        check_eq("ful_ovf", overflow_o, 1'b1);
        check_eq("ful_r0", region_cnt_o[3:0], 4'd5);
        check_eq("ful_head", out_offset_o, 32'd10);
        // Full with simultaneous pop: the write is accepted.
        out_ready_i = 1'b1;
        wr(32'd16, 32'h66);
        check_eq("pp_drop", drop_cnt_o, 4'd2);
        check_eq("pp_r0", region_cnt_o[3:0], 4'd6);
        begin
            logic [AW-1:0] exp_off [4];
            exp_off = '{32'd11, 32'd12, 32'd13, 32'd16};
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("drain_v%0d", i), out_valid_o, 1'b1);
                check_eq($sformatf("drain_o%0d", i), out_offset_o, exp_off[i]);
                tick();
            end
        end
        check_eq("drain_empty", out_valid_o, 1'b0);

        // Counter saturation: 12 more accepted writes push 6 -> 15 and stop there.
        for (int i = 0; i < 12; i++) wr(32'd30, 32'(i));
        check_eq("sat_r0", region_cnt_o[3:0], 4'd15);
        tick();
        out_ready_i = 1'b0;
        check_eq("sat_empty", out_valid_o, 1'b0);

        // Stop-PC: the coincident write is still captured.
        stop_en_i = 1'b1; stop_addr_i = 32'd187; inst_addr_i = 32'd187;
        wr(32'd20, 32'h77);
        check_eq("stp_state", state_o, 2'b10);
        check_eq("stp_done", done_o, 1'b1);
        check_eq("stp_off", out_offset_o, 32'd20);
        check_eq("stp_data", out_data_o, 32'h77);
        wr(32'd21, 32'h78);
        wr(32'd5000, 32'h79);
        check_eq("stp_um", unmatched_cnt_o, 4'd2);
        check_eq("stp_hold", out_offset_o, 32'd20);
        out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
        check_eq("stp_only1", out_valid_o, 1'b0);
        check_eq("stp_still", state_o, 2'b10);

        // Clear from STOPPED.
        stop_en_i = 1'b0;
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        check_eq("clr_state", {state_o, done_o}, 3'b000);
        check_eq("clr_cnts", {region_cnt_o, unmatched_cnt_o, drop_cnt_o}, '0);
        check_eq("clr_ovf", overflow_o, 1'b0);

        // Reset mid-capture with 3 entries queued.
        enable_i = 1'b1; tick(); enable_i = 1'b0;
        for (int i = 0; i < 3; i++) wr(32'(1 + i), 32'(i + 5));
        check_eq("mid_valid", out_valid_o, 1'b1);
        check_eq("mid_r0", region_cnt_o[3:0], 4'd3);
        RST = 1'b0; tick(); RST = 1'b1;
        check_eq("mrst_valid", out_valid_o, 1'b0);
        check_eq("mrst_state", state_o, 2'b00);
        check_eq("mrst_cnts", {region_cnt_o, unmatched_cnt_o, drop_cnt_o}, '0);
        check_eq("mrst_off", out_offset_o, '0);
        // Writes in IDLE are ignored.
        wr(32'd5, 32'h1);
        check_eq("idle_valid", out_valid_o, 1'b0);
        check_eq("idle_cnt", region_cnt_o[3:0], 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
